// File: rtl/cycle_seq_pkg.sv
// ---------------------------------------------------------------------------
// cycle_seq_pkg
//  Shared types and defaults for the machine-cycle sequencer.
//  - seq_state_t : machine-cycle state encoding (IDLE, FETCH, EXEC, EXEC2)
//  - NPH_DEFAULT : default beats per machine cycle
//  - CNT_W_DEFAULT : default width of the retired-instruction counter
//  - is_exec()   : true for both exec cycle kinds
// ---------------------------------------------------------------------------
package cycle_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        EXEC2 = 2'd3
    } seq_state_t;

    localparam int NPH_DEFAULT   = 8;
    localparam int CNT_W_DEFAULT = 16;

    function automatic logic is_exec(input seq_state_t s);
        return (s == EXEC) || (s == EXEC2);
    endfunction

endpackage

// File: rtl/phase_ring.sv
// ---------------------------------------------------------------------------
// phase_ring
//  NPH-bit one-hot beat ring. Reset and the synchronous load both put the
//  ring on beat 0; when enabled it rotates one beat per clock.
//  Ports:
//   CLK   in   1    clock
//   CLRn  in   1    asynchronous active-low reset
//   load  in   1    synchronous load to beat 0 (priority over en)
//   en    in   1    advance one beat
//   ring  out  NPH  one-hot beat register
//   last  out  1    ring is on beat NPH-1
// ---------------------------------------------------------------------------
module phase_ring
    import cycle_seq_pkg::*;
#(
    parameter int NPH = NPH_DEFAULT
) (
    input  logic           CLK,
    input  logic           CLRn,
    input  logic           load,
    input  logic           en,
    output logic [NPH-1:0] ring,
    output logic           last
);

    localparam logic [NPH-1:0] BEAT0 = {{(NPH-1){1'b0}}, 1'b1};

    logic [NPH-1:0] ring_r;

    // One-hot rotation; beat NPH-1 wraps back to beat 0.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            ring_r <= BEAT0;
        end else if (load) begin
            ring_r <= BEAT0;
        end else if (en) begin
            ring_r <= {ring_r[NPH-2:0], ring_r[NPH-1]};
        end else begin
            ring_r <= ring_r;
        end
    end

    assign ring = ring_r;
    assign last = ring_r[NPH-1];

endmodule

// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
//  Machine-cycle controller: run/stop control, FETCH -> EXEC (-> EXEC2)
//  sequencing over NPH beats, gated one-hot beats and a retired count.
//  Optional feature macro: STEP_MODE_EN (adds STEP_MODE input; when high at
//  the final exec beat the sequencer returns to IDLE after the instruction).
//  Ports:
//   CLK        in   1      clock
//   CLRn       in   1      asynchronous active-low reset
//   START      in   1      run request, honoured only in IDLE
//   STOP       in   1      stop request, latched while running
//   HALT_REQ   in   1      halt level, sampled at instruction end
//   LONG_INSN  in   1      needs EXEC2, sampled at FETCH beat NPH-1
//   STEP_MODE  in   1      (STEP_MODE_EN only) single-instruction mode
//   T          out  NPH    one-hot beat, zero when not running
//   CYC_FETCH  out  1      FETCH cycle
//   CYC_EXEC   out  1      EXEC or EXEC2 cycle
//   CYC_EXEC2  out  1      EXEC2 cycle
//   RUNNING    out  1      not IDLE
//   INSN_DONE  out  1      last beat of the final exec cycle
//   INSN_CNT   out  CNT_W  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module cycle_sequencer
    import cycle_seq_pkg::*;
#(
    parameter int NPH   = NPH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             CLRn,
    input  logic             START,
    input  logic             STOP,
    input  logic             HALT_REQ,
    input  logic             LONG_INSN,
`ifdef STEP_MODE_EN
    input  logic             STEP_MODE,
`endif
    output logic [NPH-1:0]   T,
    output logic             CYC_FETCH,
    output logic             CYC_EXEC,
    output logic             CYC_EXEC2,
    output logic             RUNNING,
    output logic             INSN_DONE,
    output logic [CNT_W-1:0] INSN_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t       state_r;
    logic             stop_pend_r;
    logic             long_q_r;
    logic [CNT_W-1:0] insn_cnt_r;

    logic [NPH-1:0]   ring_s;
    logic             last_s;
    logic             running_s;
    logic             final_s;
    logic             step_s;
    logic             stop_now_s;

`ifdef STEP_MODE_EN
    assign step_s = STEP_MODE;
`else
    assign step_s = 1'b0;
`endif

    // The ring sits on beat 0 throughout IDLE so the first FETCH beat is T[0].
    phase_ring #(.NPH(NPH)) u_ring (
        .CLK  (CLK),
        .CLRn (CLRn),
        .load (state_r == IDLE),
        .en   (running_s),
        .ring (ring_s),
        .last (last_s)
    );

    assign running_s  = (state_r != IDLE);
    // Final exec beat: last beat of a short EXEC, or of EXEC2.
    assign final_s    = last_s && (((state_r == EXEC) && !long_q_r) || (state_r == EXEC2));
    assign stop_now_s = stop_pend_r || STOP || HALT_REQ || step_s;

    // Machine-cycle FSM; every transition out of a running state waits for the last beat.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state_r  <= IDLE;
            long_q_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= (START && !STOP) ? FETCH : IDLE;
                end
                FETCH: begin
                    if (last_s) begin
                        long_q_r <= LONG_INSN;
                        state_r  <= EXEC;
                    end
                end
                EXEC: begin
                    if (last_s) begin
                        if (long_q_r) begin
                            state_r <= EXEC2;
                        end else begin
                            state_r <= stop_now_s ? IDLE : FETCH;
                        end
                    end
                end
                EXEC2: begin
                    if (last_s) begin
                        state_r <= stop_now_s ? IDLE : FETCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Stop latch: armed only while running, consumed when the instruction retires.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            stop_pend_r <= 1'b0;
        end else if (state_r == IDLE) begin
            stop_pend_r <= 1'b0;
        end else if (final_s && stop_now_s) begin
            stop_pend_r <= 1'b0;
        end else if (STOP) begin
            stop_pend_r <= 1'b1;
        end else begin
            stop_pend_r <= stop_pend_r;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            insn_cnt_r <= {CNT_W{1'b0}};
        end else if (final_s) begin
            insn_cnt_r <= insn_cnt_r + CNT_ONE;
        end else begin
            insn_cnt_r <= insn_cnt_r;
        end
    end

    assign T         = ring_s & {NPH{running_s}};
    assign CYC_FETCH = (state_r == FETCH);
    assign CYC_EXEC  = is_exec(state_r);
    assign CYC_EXEC2 = (state_r == EXEC2);
    assign RUNNING   = running_s;
    assign INSN_DONE = final_s;
    assign INSN_CNT  = insn_cnt_r;

endmodule
